branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor with four counter banks.
// Queries are combinational; training happens at commit, one counter per
// committed branch. Reset is synchronous and active high.
//
// Optional feature: define PREDICTOR_HISTORY_EN to select the bank from a
// 2-bit global history register. Without it, every query uses bank 0 (a
// plain bimodal predictor), while updates still go to predictor_selection.

// One bank of 2-bit counters, one instance per selection value.
module branch_predictor_bank #(
    parameter int LOCAL_WIDTH = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   upd_en,
    input  logic                   upd_taken,
    input  logic [LOCAL_WIDTH-1:0] upd_addr,
    input  logic [LOCAL_WIDTH-1:0] rd_addr,
    output logic                   rd_taken
);
    localparam int ENTRIES = 1 << LOCAL_WIDTH;

    logic [ENTRIES-1:0][1:0] cnt;
    logic [1:0]              cur;
    logic [1:0]              nxt;

    // Read port sees the registered value, so a same-cycle update is invisible.
    assign rd_taken = cnt[rd_addr][1];
    assign cur      = cnt[upd_addr];

    // Saturating step: no wrap at either end.
    always_comb begin
        nxt = cur;
        if (upd_taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
    end

    // Reset to weakly-not-taken everywhere; otherwise touch only the indexed entry.
    always_ff @(posedge clk_in) begin
        if (rst_in)      cnt           <= {ENTRIES{2'b01}};
        else if (upd_en) cnt[upd_addr] <= nxt;
    end
endmodule

module branch_predictor #(
    parameter int LOCAL_WIDTH = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   predictor_signal,
    input  logic                   predictor_branch,
    input  logic [LOCAL_WIDTH-1:0] predictor_addr,
    input  logic [1:0]             predictor_selection,
    input  logic [31:0]            query_pc,
    output logic                   query_branch,
    output logic [LOCAL_WIDTH-1:0] query_addr,
    output logic [1:0]             query_selection
);
    localparam int BANK_WIDTH = 2;
    localparam int NUM_BANKS  = 1 << BANK_WIDTH;

    logic                 upd_fire;
    logic [NUM_BANKS-1:0] bank_upd;
    logic [NUM_BANKS-1:0] bank_taken;
    logic                 unused_pc_bits;

    // Word-aligned PC: the low two bits and the bits above the index carry no information here.
    assign query_addr     = query_pc[LOCAL_WIDTH+1:2];
    assign unused_pc_bits = ^{query_pc[31:LOCAL_WIDTH+2], query_pc[1:0]};

    // rdy_in low stalls training; the ROB keeps the strobe until it is accepted.
    assign upd_fire = ~rst_in & rdy_in & predictor_signal;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign bank_upd[b] = upd_fire & (predictor_selection == BANK_WIDTH'(b));

            branch_predictor_bank #(
                .LOCAL_WIDTH (LOCAL_WIDTH)
            ) u_bank (
                .clk_in    (clk_in),
                .rst_in    (rst_in),
                .upd_en    (bank_upd[b]),
                .upd_taken (predictor_branch),
                .upd_addr  (predictor_addr),
                .rd_addr   (query_addr),
                .rd_taken  (bank_taken[b])
            );
        end
    endgenerate

    assign query_branch = bank_taken[query_selection];

`ifdef PREDICTOR_HISTORY_EN
    logic [1:0] ghr;

    assign query_selection = ghr;

    // Shift in the committed outcome; queries this cycle still see the old history.
    always_ff @(posedge clk_in) begin
        if (rst_in)        ghr <= 2'b00;
        else if (upd_fire) ghr <= {ghr[0], predictor_branch};
    end
`else
    assign query_selection = 2'b00;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. Default build checks the bimodal
// path; with PREDICTOR_HISTORY_EN defined it checks global-history selection.
module tb_branch_predictor;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        predictor_signal;
    logic        predictor_branch;
    logic [5:0]  predictor_addr;
    logic [1:0]  predictor_selection;
    logic [31:0] query_pc;
    logic        query_branch;
    logic [5:0]  query_addr;
    logic [1:0]  query_selection;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    branch_predictor #(.LOCAL_WIDTH(6)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .predictor_signal    (predictor_signal),
        .predictor_branch    (predictor_branch),
        .predictor_addr      (predictor_addr),
        .predictor_selection (predictor_selection),
        .query_pc            (query_pc),
        .query_branch        (query_branch),
        .query_addr          (query_addr),
        .query_selection     (query_selection)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic upd(input logic [5:0] a, input logic [1:0] s, input logic t);
        predictor_signal    = 1'b1;
        predictor_addr      = a;
        predictor_selection = s;
        predictor_branch    = t;
        tick();
        predictor_signal    = 1'b0;
        #1;
    endtask

    task automatic q(input logic [31:0] pc);
        query_pc = pc;
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; predictor_signal = 1'b0; predictor_branch = 1'b0;
        predictor_addr = '0; predictor_selection = '0; query_pc = '0;
        tick(); tick();
        rst_in = 1'b0;
        #1;

`ifndef PREDICTOR_HISTORY_EN
        // Reset state
        q(32'h0000_0010);
        chk("rst_addr", 32'(query_addr), 32'd4);
        chk("rst_pred", 32'(query_branch), 32'd0);
        chk("rst_sel", 32'(query_selection), 32'd0);
        q(32'h0000_00FC);
        chk("addr_top", 32'(query_addr), 32'd63);
        chk("pred_top", 32'(query_branch), 32'd0);
        q(32'hFFFF_FF13);
        chk("addr_hi_bits", 32'(query_addr), 32'd4);

        // Three taken: 01->10->11->11
        q(32'h0000_0010);
        upd(6'd4, 2'd0, 1'b1); chk("tk1", 32'(query_branch), 32'd1);
        upd(6'd4, 2'd0, 1'b1); chk("tk2", 32'(query_branch), 32'd1);
        upd(6'd4, 2'd0, 1'b1); chk("tk3", 32'(query_branch), 32'd1);
        // Four not-taken: 11->10->01->00->00
        upd(6'd4, 2'd0, 1'b0); chk("nt1", 32'(query_branch), 32'd1);
        upd(6'd4, 2'd0, 1'b0); chk("nt2", 32'(query_branch), 32'd0);
        upd(6'd4, 2'd0, 1'b0); chk("nt3", 32'(query_branch), 32'd0);
        upd(6'd4, 2'd0, 1'b0); chk("nt4", 32'(query_branch), 32'd0);
        // From 00: one taken -> 01 (still 0), second -> 10
        upd(6'd4, 2'd0, 1'b1); chk("floor_tk1", 32'(query_branch), 32'd0);
        upd(6'd4, 2'd0, 1'b1); chk("floor_tk2", 32'(query_branch), 32'd1);

        // Other banks / indices untouched
        upd(6'd5, 2'd1, 1'b1);
        upd(6'd5, 2'd1, 1'b1);
        q(32'h0000_0014); chk("bank_iso", 32'(query_branch), 32'd0);
        q(32'h0000_0018); chk("idx_iso", 32'(query_branch), 32'd0);

        // Same-cycle update and query: pre-update value visible
        q(32'h0000_001C);
        predictor_signal = 1'b1; predictor_addr = 6'd7; predictor_selection = 2'd0; predictor_branch = 1'b1;
        #1;
        chk("rbw_same", 32'(query_branch), 32'd0);
        tick();
        predictor_signal = 1'b0;
        #1;
        chk("rbw_next", 32'(query_branch), 32'd1);

        // Stall: strobe ignored while rdy_in is low
        q(32'h0000_0018);
        rdy_in = 1'b0;
        upd(6'd6, 2'd0, 1'b1);
        upd(6'd6, 2'd0, 1'b1);
        chk("stall_hold", 32'(query_branch), 32'd0);
        rdy_in = 1'b1;
        upd(6'd6, 2'd0, 1'b1);
        chk("stall_release", 32'(query_branch), 32'd1);

        // Reset beats a simultaneous update and restores 01 everywhere
        rst_in = 1'b1;
        upd(6'd4, 2'd0, 1'b1);
        rst_in = 1'b0;
        #1;
        q(32'h0000_0010); chk("rst_upd_4", 32'(query_branch), 32'd0);
        q(32'h0000_001C); chk("rst_upd_7", 32'(query_branch), 32'd0);
        q(32'h0000_0010);
        upd(6'd4, 2'd0, 1'b1); chk("rst_val_tk", 32'(query_branch), 32'd1);
        upd(6'd4, 2'd0, 1'b0); chk("rst_val_nt", 32'(query_branch), 32'd0);
`else
        // Reset state
        q(32'h0000_0010);
        chk("rst_addr", 32'(query_addr), 32'd4);
        chk("rst_pred", 32'(query_branch), 32'd0);
        chk("rst_sel", 32'(query_selection), 32'd0);

        // Taken: old ghr visible in the update cycle, then 01
        predictor_signal = 1'b1; predictor_addr = 6'd4; predictor_selection = 2'd0; predictor_branch = 1'b1;
        #1;
        chk("ghr_same", 32'(query_selection), 32'd0);
        tick();
        predictor_signal = 1'b0;
        #1;
        chk("ghr_t", 32'(query_selection), 32'd1);
        chk("bank1_pred", 32'(query_branch), 32'd0);
        upd(6'd4, 2'd1, 1'b0); chk("ghr_tn", 32'(query_selection), 32'd2);
        upd(6'd4, 2'd2, 1'b1); chk("ghr_tnt", 32'(query_selection), 32'd1);
        chk("bank1_after", 32'(query_branch), 32'd0);

        // Stall leaves ghr alone
        rdy_in = 1'b0;
        upd(6'd4, 2'd1, 1'b1);
        chk("ghr_stall", 32'(query_selection), 32'd1);
        rdy_in = 1'b1;

        // Reset with update clears ghr and counters
        rst_in = 1'b1;
        upd(6'd4, 2'd0, 1'b1);
        rst_in = 1'b0;
        #1;
        chk("ghr_rst", 32'(query_selection), 32'd0);
        chk("ghr_rst_pred", 32'(query_branch), 32'd0);
        upd(6'd4, 2'd0, 1'b1); chk("ghr_post_rst", 32'(query_selection), 32'd1);
        chk("ghr_post_pred", 32'(query_branch), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
